// File: rtl/tug_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : tug_match_controller
// Purpose  : Tug-of-war match sequencer. Tracks the rope-light position,
//            arbitrates the two player keys, keeps per-player scores on two
//            active-low 7-segment digits and declares a match winner.
// Options  : TUG_AUTO_RESTART_EN - when defined, the OVER state times out
//            after 4*HOLD_CYCLES clocks and returns to IDLE on its own.
// Revision : 1.0 - initial release
// ============================================================================
module tug_match_controller #(
    parameter int NUM_LIGHTS  = 9,   // odd, 3..10
    parameter int WIN_SCORE   = 7,   // 1..9, one decimal digit per score
    parameter int HOLD_CYCLES = 4    // >= 1
) (
    input  logic                  clock,
    input  logic                  reset,      // asynchronous, active-low
    input  logic                  start,
    input  logic                  LeftKEY,
    input  logic                  RightKEY,
    output logic [NUM_LIGHTS-1:0] LEDR,
    output logic [6:0]            HEX5,
    output logic [6:0]            HEX0,
    output logic                  match_done,
    output logic [1:0]            winner
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int POS_W   = $clog2(NUM_LIGHTS);
    localparam int SCORE_W = $clog2(WIN_SCORE + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

    localparam logic [POS_W-1:0]      POS_CENTRE  = POS_W'(NUM_LIGHTS / 2);
    localparam logic [POS_W-1:0]      POS_LEFT    = POS_W'(NUM_LIGHTS - 1);
    localparam logic [POS_W-1:0]      POS_RIGHT   = '0;
    localparam logic [SCORE_W-1:0]    SCORE_WIN   = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]     HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [NUM_LIGHTS-1:0] LEDR_CENTRE = NUM_LIGHTS'(1) << (NUM_LIGHTS / 2);

    // Match state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_POINT = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    // Winner encoding on the output port
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    // Which player scored the point currently being held
    localparam logic SCORER_LEFT  = 1'b0;
    localparam logic SCORER_RIGHT = 1'b1;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,     state_d;
    logic [POS_W-1:0]   pos_q,       pos_d;
    logic [SCORE_W-1:0] score_l_q,   score_l_d;
    logic [SCORE_W-1:0] score_r_q,   score_r_d;
    logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic               scorer_q,    scorer_d;
    logic [1:0]         winner_q,    winner_d;
    logic               left_key_q,  left_key_d;
    logic               right_key_q, right_key_d;

`ifdef TUG_AUTO_RESTART_EN
    localparam int OVER_CYCLES = 4 * HOLD_CYCLES;
    localparam int OVER_W      = $clog2(OVER_CYCLES + 1);
    localparam logic [OVER_W-1:0] OVER_LAST = OVER_W'(OVER_CYCLES - 1);

    logic [OVER_W-1:0] over_cnt_q, over_cnt_d;
`endif

    // ------------------------------------------------------------------------
    // Key edge detection: a press is a rising edge of the synchronised key.
    // A press by both players in the same cycle cancels out entirely.
    // ------------------------------------------------------------------------
    logic w_press_l;
    logic w_press_r;
    logic w_press_l_only;
    logic w_press_r_only;
    logic [SCORE_W-1:0] w_scorer_score;

    assign w_press_l      = LeftKEY  & ~left_key_q;
    assign w_press_r      = RightKEY & ~right_key_q;
    assign w_press_l_only = w_press_l & ~w_press_r;
    assign w_press_r_only = w_press_r & ~w_press_l;
    assign w_scorer_score = (scorer_q == SCORER_RIGHT) ? score_r_q : score_l_q;

    // ------------------------------------------------------------------------
    // 7-segment decode, active-low, segment g is the MSB
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Next-state logic for the match sequencer, position, scores and winner
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        hold_cnt_d  = hold_cnt_q;
        scorer_d    = scorer_q;
        winner_d    = winner_q;
        left_key_d  = LeftKEY;
        right_key_d = RightKEY;
`ifdef TUG_AUTO_RESTART_EN
        over_cnt_d  = over_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Light sits in the middle; keys have no effect until start
                pos_d = POS_CENTRE;
                if (start) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (w_press_l_only) begin
                    if (pos_q == POS_LEFT) begin
                        // Pulled off the left edge: point to the left player
                        if (score_l_q != SCORE_WIN) begin
                            score_l_d = score_l_q + 1'b1;
                        end
                        scorer_d   = SCORER_LEFT;
                        hold_cnt_d = '0;
                        state_d    = ST_POINT;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (w_press_r_only) begin
                    if (pos_q == POS_RIGHT) begin
                        // Pulled off the right edge: point to the right player
                        if (score_r_q != SCORE_WIN) begin
                            score_r_d = score_r_q + 1'b1;
                        end
                        scorer_d   = SCORER_RIGHT;
                        hold_cnt_d = '0;
                        state_d    = ST_POINT;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end

            ST_POINT: begin
                // Lights stay dark for HOLD_CYCLES clocks, then either the
                // match ends or play resumes from the centre
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (w_scorer_score == SCORE_WIN) begin
                        state_d  = ST_OVER;
                        winner_d = (scorer_q == SCORER_RIGHT) ? WIN_RIGHT : WIN_LEFT;
`ifdef TUG_AUTO_RESTART_EN
                        over_cnt_d = '0;
`endif
                    end else begin
                        pos_d   = POS_CENTRE;
                        state_d = ST_PLAY;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                // ST_OVER: winner is held until the match is cleared
                if (start) begin
                    state_d   = ST_IDLE;
                    pos_d     = POS_CENTRE;
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = WIN_NONE;
                end
`ifdef TUG_AUTO_RESTART_EN
                else if (over_cnt_q == OVER_LAST) begin
                    state_d   = ST_IDLE;
                    pos_d     = POS_CENTRE;
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = WIN_NONE;
                end else begin
                    over_cnt_d = over_cnt_q + 1'b1;
                end
`else
                // Without auto-restart the finished match waits for start
`endif
            end
        endcase
    end

    // Match state registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pos_q       <= POS_CENTRE;
            score_l_q   <= '0;
            score_r_q   <= '0;
            hold_cnt_q  <= '0;
            scorer_q    <= SCORER_LEFT;
            winner_q    <= WIN_NONE;
            left_key_q  <= 1'b0;
            right_key_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            hold_cnt_q  <= hold_cnt_d;
            scorer_q    <= scorer_d;
            winner_q    <= winner_d;
            left_key_q  <= left_key_d;
            right_key_q <= right_key_d;
        end
    end

`ifdef TUG_AUTO_RESTART_EN
    // Timeout counter for the automatic return from OVER
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            over_cnt_q <= '0;
        end else begin
            over_cnt_q <= over_cnt_d;
        end
    end
`endif

    // Light pattern: centre in IDLE, position in PLAY, dark in POINT, all lit in OVER
    always_comb begin
        case (state_q)
            ST_IDLE:  LEDR = LEDR_CENTRE;
            ST_PLAY:  LEDR = NUM_LIGHTS'(1) << pos_q;
            ST_POINT: LEDR = '0;
            default:  LEDR = '1;
        endcase
    end

    assign HEX5       = seg7(4'(score_l_q));
    assign HEX0       = seg7(4'(score_r_q));
    assign match_done = (state_q == ST_OVER);
    assign winner     = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_tug_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_tug_match_controller
// Purpose  : Directed self-checking bench for tug_match_controller with the
//            default parameters (9 lights, win at 7, 4-clock point hold).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tug_match_controller;

    logic       clock;
    logic       reset;
    logic       start;
    logic       LeftKEY;
    logic       RightKEY;
    logic [8:0] LEDR;
    logic [6:0] HEX5;
    logic [6:0] HEX0;
    logic       match_done;
    logic [1:0] winner;

    int checks   = 0;
    int failures = 0;

    localparam logic [8:0] L_CENTRE = 9'b000010000;
    localparam logic [8:0] L_POS3   = 9'b000001000;
    localparam logic [8:0] L_POS5   = 9'b000100000;
    localparam logic [8:0] L_POS6   = 9'b001000000;
    localparam logic [8:0] L_POS8   = 9'b100000000;
    localparam logic [8:0] L_POS0   = 9'b000000001;
    localparam logic [8:0] L_DARK   = 9'b000000000;
    localparam logic [8:0] L_ALL    = 9'b111111111;
    localparam logic [6:0] SEG0     = 7'b1000000;
    localparam logic [6:0] SEG1     = 7'b1111001;
    localparam logic [6:0] SEG7     = 7'b1111000;

    // Hand-entered 7-seg patterns for right-player scores 1..7
    logic [6:0] seg_tbl [1:7];

    tug_match_controller #(
        .NUM_LIGHTS  (9),
        .WIN_SCORE   (7),
        .HOLD_CYCLES (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .LeftKEY    (LeftKEY),
        .RightKEY   (RightKEY),
        .LEDR       (LEDR),
        .HEX5       (HEX5),
        .HEX0       (HEX0),
        .match_done (match_done),
        .winner     (winner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_left();
        LeftKEY = 1'b1;
        tick(1);
        LeftKEY = 1'b0;
        tick(1);
    endtask

    task automatic press_right();
        RightKEY = 1'b1;
        tick(1);
        RightKEY = 1'b0;
        tick(1);
    endtask

    // Run-length guard
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seg_tbl[1] = 7'b1111001;
        seg_tbl[2] = 7'b0100100;
        seg_tbl[3] = 7'b0110000;
        seg_tbl[4] = 7'b0011001;
        seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010;
        seg_tbl[7] = 7'b1111000;

        reset    = 1'b0;
        start    = 1'b0;
        LeftKEY  = 1'b0;
        RightKEY = 1'b0;

        // ---- Reset, then idle with no start ----
        tick(2);
        check("rst_ledr",   16'(LEDR), 16'(L_CENTRE));
        check("rst_hex5",   16'(HEX5), 16'(SEG0));
        check("rst_hex0",   16'(HEX0), 16'(SEG0));
        check("rst_winner", 16'(winner), 16'(2'b00));
        check("rst_done",   16'(match_done), 16'(1'b0));
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("idle_ledr",   16'(LEDR), 16'(L_CENTRE));
            check("idle_winner", 16'(winner), 16'(2'b00));
        end
        press_left();
        check("idle_press_ignored", 16'(LEDR), 16'(L_CENTRE));

        // ---- Start and single moves ----
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("play_ledr_centre", 16'(LEDR), 16'(L_CENTRE));
        press_left();
        check("move_left_one", 16'(LEDR), 16'(L_POS5));
        LeftKEY = 1'b1;
        tick(1);
        check("hold_first_move", 16'(LEDR), 16'(L_POS6));
        tick(5);
        check("hold_single_move", 16'(LEDR), 16'(L_POS6));
        LeftKEY = 1'b0;
        tick(1);
        press_right();
        press_right();
        check("back_to_centre", 16'(LEDR), 16'(L_CENTRE));

        // ---- Simultaneous press cancels ----
        LeftKEY  = 1'b1;
        RightKEY = 1'b1;
        tick(1);
        check("simul_ledr", 16'(LEDR), 16'(L_CENTRE));
        check("simul_hex5", 16'(HEX5), 16'(SEG0));
        check("simul_hex0", 16'(HEX0), 16'(SEG0));
        LeftKEY  = 1'b0;
        RightKEY = 1'b0;
        tick(1);

        // ---- Left player scores a point ----
        for (int i = 0; i < 4; i++) press_left();
        check("left_edge_pos", 16'(LEDR), 16'(L_POS8));
        LeftKEY = 1'b1;
        tick(1);
        check("point_hex5", 16'(HEX5), 16'(SEG1));
        check("point_hex0", 16'(HEX0), 16'(SEG0));
        check("point_dark1", 16'(LEDR), 16'(L_DARK));
        LeftKEY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("point_dark", 16'(LEDR), 16'(L_DARK));
        end
        tick(1);
        check("point_recentre", 16'(LEDR), 16'(L_CENTRE));

        // ---- Right player wins the match with 7 points ----
        for (int k = 1; k <= 7; k++) begin
            for (int i = 0; i < 4; i++) press_right();
            check("right_edge_pos", 16'(LEDR), 16'(L_POS0));
            RightKEY = 1'b1;
            tick(1);
            check("right_score_hex0", 16'(HEX0), 16'(seg_tbl[k]));
            check("right_point_dark", 16'(LEDR), 16'(L_DARK));
            RightKEY = 1'b0;
            tick(3);
            check("not_done_in_hold", 16'(match_done), 16'(1'b0));
            tick(1);
            if (k < 7) check("right_recentre", 16'(LEDR), 16'(L_CENTRE));
        end
        check("over_done",   16'(match_done), 16'(1'b1));
        check("over_winner", 16'(winner), 16'(2'b10));
        check("over_hex0",   16'(HEX0), 16'(SEG7));
        check("over_hex5",   16'(HEX5), 16'(SEG1));
        check("over_ledr",   16'(LEDR), 16'(L_ALL));
        press_left();
        tick(3);
        check("over_keys_ignored", 16'(LEDR), 16'(L_ALL));
        check("over_winner_held",  16'(winner), 16'(2'b10));
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("clear_hex0",   16'(HEX0), 16'(SEG0));
        check("clear_hex5",   16'(HEX5), 16'(SEG0));
        check("clear_winner", 16'(winner), 16'(2'b00));
        check("clear_done",   16'(match_done), 16'(1'b0));
        check("clear_ledr",   16'(LEDR), 16'(L_CENTRE));

        // ---- Reset in the middle of a point hold ----
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) press_right();
        RightKEY = 1'b1;
        tick(1);
        RightKEY = 1'b0;
        tick(1);
        check("pre_reset_hex0", 16'(HEX0), 16'(SEG1));
        check("pre_reset_dark", 16'(LEDR), 16'(L_DARK));
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_ledr",   16'(LEDR), 16'(L_CENTRE));
        check("async_rst_hex0",   16'(HEX0), 16'(SEG0));
        check("async_rst_winner", 16'(winner), 16'(2'b00));
        tick(1);
        reset = 1'b1;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        press_right();
        check("post_reset_move", 16'(LEDR), 16'(L_POS3));
        check("post_reset_hex0", 16'(HEX0), 16'(SEG0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tug_match_controller.md
Name: tug_match_controller

Overview:
- Match sequencer for the tug-of-war game. Owns the rope-light position, arbitrates the two player keys, and awards points when a player pulls the light off their edge.
- Keeps per-player scores, shows them on two 7-seg digits, and declares a match winner at WIN_SCORE.
- Sits between the synchronised player keys and the LEDR/HEX outputs.

Parameters:
- NUM_LIGHTS, 9: rope lights. Odd, 3..10. Centre index = NUM_LIGHTS/2.
- WIN_SCORE, 7: points that win the match. 1..9, so each score fits one decimal digit.
- HOLD_CYCLES, 4: clocks spent in POINT before the light recentres. Must be ≥1.

Ports:
- clock  in  1  system clock. All state changes on its rising edge.
- reset  in  1  asynchronous, active-low. 0 clears all state immediately.
- start  in  1  level input. Begins a match from IDLE; clears a finished match in OVER.
- LeftKEY  in  1  left player key. Synchronised, 1 = pressed.
- RightKEY  in  1  right player key. Synchronised, 1 = pressed.
- LEDR  out  NUM_LIGHTS  one-hot light position. Bit NUM_LIGHTS-1 is the leftmost light.
- HEX5  out  7  left score, active-low 7-seg.
- HEX0  out  7  right score, active-low 7-seg.
- match_done  out  1  high while in OVER.
- winner  out  2  00 none, 01 left, 10 right. Holds its value until the match is cleared.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, pos=centre, both scores 0.
  - Key edge registers = 0.
  - LEDR = one-hot centre; HEX0 = HEX5 = 7'b1000000 (digit 0).
  - match_done=0, winner=00.
- Press detection:
  - pressL = LeftKEY & ~LeftKEY_q; pressR likewise. The _q registers update every clock.
  - Holding a key produces exactly one press.
  - pressL and pressR in the same cycle: both ignored, no move, no point.
- States: IDLE, PLAY, POINT, OVER.
- IDLE:
  - LEDR = centre. Presses ignored.
  - start=1 → PLAY on the next edge.
- PLAY (moves apply on the edge ending the press cycle):
  - pressL only:
    - pos<NUM_LIGHTS-1 → pos+1.
    - pos=NUM_LIGHTS-1 → left score +1, enter POINT, winner_pt=left.
  - pressR only:
    - pos>0 → pos-1.
    - pos=0 → right score +1, enter POINT.
  - start is ignored.
- POINT:
  - LEDR = all zeros. Hold counter runs HOLD_CYCLES clocks, keys ignored.
  - On expiry, if the scoring player's score = WIN_SCORE → OVER and set winner.
  - Otherwise pos=centre → PLAY.
  - The score increment is visible on HEX on the edge that enters POINT.
- OVER:
  - LEDR all ones, match_done=1, winner held.
  - Keys ignored.
  - start=1 → IDLE: scores=0, pos=centre, winner=00.
- Score arithmetic: width $clog2(WIN_SCORE+1). Never exceeds WIN_SCORE; no wrap.
- HEX encoding: active-low segment patterns for 0-9. Values >9 are unreachable by parameter constraint.
- Reset mid-operation (any state, including mid-POINT): immediate return to reset values; the hold counter is cleared.

Optional Feature:
- Macro: TUG_AUTO_RESTART_EN.
- Defined: OVER lasts exactly 4*HOLD_CYCLES clocks, then returns to IDLE automatically with scores and winner cleared. start in OVER may still clear early.
- Undefined: OVER holds until start or reset.

Test Plan:
- Reset then idle: reset=0 for 2 clocks, release, no start → LEDR=9'b000010000, HEX0=HEX5=7'b1000000, winner=00 across 5 clocks.
- Single moves: start 1 clock, then one LeftKEY pulse (1 clock high) → LEDR=9'b000100000. Holding LeftKEY high 6 clocks → only one move.
- Simultaneous press: at pos=centre, LeftKEY and RightKEY rise in the same clock → LEDR unchanged, scores unchanged.
- Score a point: from centre, 5 separate Left presses (4 moves + 1 at edge) → HEX5=7'b1111001 (1) on the scoring edge. LEDR=0 for 4 clocks, then the centre light.
- Match win: right player scores 7 points → after the 7th POINT hold, match_done=1, winner=10, HEX0=7'b1111000 (7), LEDR all ones. start=1 → IDLE with both HEX=0.
- Reset mid-POINT: assert reset=0 in the 2nd hold clock → outputs return to reset values asynchronously, before the next clock edge. After release and start, the next Right press moves pos to 3.
